// File: rtl/seq_pkg.sv
// seq_pkg: opcodes, fixed ALU codes, sequencer state and opcode-class
// enumerations, and the packed control word shared by the sequencer files.
package seq_pkg;

  // Load / store
  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  // Register-register ALU ops (opcode doubles as ALU code)
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  // Immediate ALU ops
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  // Multiply / divide and unary ops
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  // Control transfer
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_JAL  = 5'b10100;
  localparam logic [4:0] OP_JR   = 5'b10101;
  // I/O and special-register moves
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFLO = 5'b11000;
  localparam logic [4:0] OP_MFHI = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  // ALU codes used outside the opcode pass-through
  localparam logic [4:0] ALU_ADD = 5'b00011;
  localparam logic [4:0] ALU_INC = 5'b11100;

  typedef enum logic [3:0] {
    T0    = 4'd0,
    T1    = 4'd1,
    T2    = 4'd2,
    T3    = 4'd3,
    T4    = 4'd4,
    T5    = 4'd5,
    T6    = 4'd6,
    T7    = 4'd7,
    HALT  = 4'd8,
    PAUSE = 4'd9
  } state_t;

  typedef enum logic [3:0] {
    CLS_RTYPE  = 4'd0,
    CLS_IMM    = 4'd1,
    CLS_LDI    = 4'd2,
    CLS_LD     = 4'd3,
    CLS_ST     = 4'd4,
    CLS_MULDIV = 4'd5,
    CLS_UNARY  = 4'd6,
    CLS_BR     = 4'd7,
    CLS_JAL    = 4'd8,
    CLS_JR     = 4'd9,
    CLS_IN     = 4'd10,
    CLS_OUT    = 4'd11,
    CLS_MFHI   = 4'd12,
    CLS_MFLO   = 4'd13,
    CLS_NOP    = 4'd14,
    CLS_HALT   = 4'd15
  } opclass_t;

  // Every datapath control line in one word
  typedef struct packed {
    logic       gra;
    logic       grb;
    logic       grc;
    logic       rIn;
    logic       rOut;
    logic       baOut;
    logic       hiIn;
    logic       loIn;
    logic       zIn;
    logic       pcIn;
    logic       mdrIn;
    logic       marIn;
    logic       yIn;
    logic       oPortIn;
    logic       irIn;
    logic       hiOut;
    logic       loOut;
    logic       zHiOut;
    logic       zLoOut;
    logic       pcOut;
    logic       mdrOut;
    logic       iPortOut;
    logic       cOut;
    logic       read;
    logic       write;
    logic       conIn;
    logic [4:0] aluCode;
  } ctrl_t;

  // Immediate forms reuse the ALU code of their register-register sibling
  function automatic logic [4:0] immAluCode(input logic [4:0] op);
    logic [4:0] code;
    case (op)
      OP_ADDI: code = OP_ADD;
      OP_ANDI: code = OP_AND;
      OP_ORI:  code = OP_OR;
      default: code = OP_ADD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/datapath_sequencer_opcode_class_decode.sv
// opcode_class_decode: combinational map from the 5-bit opcode to the
// execute-sequence family it follows. Unassigned opcodes behave as nop.
module opcode_class_decode
  import seq_pkg::*;
(
  input  logic [4:0] opcode,
  output opclass_t   opClass
);

  // Group opcodes by the execute sequence they share
  always_comb begin
    opClass = CLS_NOP;
    case (opcode)
      OP_LD:   opClass = CLS_LD;
      OP_LDI:  opClass = CLS_LDI;
      OP_ST:   opClass = CLS_ST;
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL,
      OP_SHR, OP_SHRA, OP_SHL:
               opClass = CLS_RTYPE;
      OP_ADDI, OP_ANDI, OP_ORI:
               opClass = CLS_IMM;
      OP_DIV, OP_MUL:
               opClass = CLS_MULDIV;
      OP_NEG, OP_NOT:
               opClass = CLS_UNARY;
      OP_BR:   opClass = CLS_BR;
      OP_JAL:  opClass = CLS_JAL;
      OP_JR:   opClass = CLS_JR;
      OP_IN:   opClass = CLS_IN;
      OP_OUT:  opClass = CLS_OUT;
      OP_MFLO: opClass = CLS_MFLO;
      OP_MFHI: opClass = CLS_MFHI;
      OP_HALT: opClass = CLS_HALT;
      default: opClass = CLS_NOP;
    endcase
  end

endmodule

// File: rtl/datapath_sequencer.sv
// datapath_sequencer: hardwired fetch/execute control sequencer.
// Controls are Moore-decoded from the state register plus IR[31:27]; IR is
// loaded by the datapath during fetch, so decode has to follow it directly.
// Controls are held low while clear is asserted. The first edge after reset
// release repeats T0 (harmless: T0 only recomputes MAR and PC+1) and raises Run.
// Optional feature macro: SEQ_STOP_EN adds the Stop input and a PAUSE state
// entered in place of T0 when Stop is high at the end of an instruction.
module datapath_sequencer
  import seq_pkg::*;
(
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] IR,
  input  logic        ConOut,
`ifdef SEQ_STOP_EN
  input  logic        Stop,
`endif
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        RIn,
  output logic        ROut,
  output logic        BAOut,
  output logic        HiIn,
  output logic        LoIn,
  output logic        ZIn,
  output logic        PCIn,
  output logic        MDRIn,
  output logic        MARIn,
  output logic        YIn,
  output logic        OPortIn,
  output logic        IRIn,
  output logic        HiOut,
  output logic        LoOut,
  output logic        ZHiOut,
  output logic        ZLoOut,
  output logic        PCOut,
  output logic        MDROut,
  output logic        IPortOut,
  output logic        COut,
  output logic        Read,
  output logic        Write,
  output logic        ConIn,
  output logic [4:0]  ALUCode,
  output logic        Run
);

  logic [4:0] opcode_s;
  logic       unusedIr_s;
  opclass_t   opClass_s;
  state_t     state_r;
  state_t     nextState_s;
  state_t     lastStep_s;
  state_t     finishState_s;
  logic       run_r;
  ctrl_t      ctrl_s;
  ctrl_t      ctrlOut_s;

  assign opcode_s   = IR[31:27];
  assign unusedIr_s = ^IR[26:0];

  opcode_class_decode uDecode (
    .opcode  (opcode_s),
    .opClass (opClass_s)
  );

  // Final step of each class; nop, halt and undefined opcodes end at T2
  always_comb begin
    lastStep_s = T2;
    case (opClass_s)
      CLS_RTYPE, CLS_IMM, CLS_LDI:               lastStep_s = T5;
      CLS_LD, CLS_ST:                            lastStep_s = T7;
      CLS_MULDIV, CLS_BR:                        lastStep_s = T6;
      CLS_UNARY, CLS_JAL:                        lastStep_s = T4;
      CLS_JR, CLS_IN, CLS_OUT, CLS_MFHI, CLS_MFLO: lastStep_s = T3;
      default:                                   lastStep_s = T2;
    endcase
  end

  // Where a completed instruction goes: T0, or PAUSE on a stop request
  always_comb begin
`ifdef SEQ_STOP_EN
    if (Stop) begin
      finishState_s = PAUSE;
    end else begin
      finishState_s = T0;
    end
`else
    finishState_s = T0;
`endif
  end

  // Step through the sequence; T0 repeats once after reset until Run is up
  always_comb begin
    nextState_s = T0;
    case (state_r)
      T0: begin
        if (run_r) begin
          nextState_s = T1;
        end else begin
          nextState_s = T0;
        end
      end
      T1: nextState_s = T2;
      T2, T3, T4, T5, T6, T7: begin
        if ((state_r == T2) && (opClass_s == CLS_HALT)) begin
          nextState_s = HALT;
        end else if ((state_r == lastStep_s) || (state_r == T7)) begin
          nextState_s = finishState_s;
        end else begin
          nextState_s = state_t'(state_r + 4'd1);
        end
      end
      HALT: nextState_s = HALT;
`ifdef SEQ_STOP_EN
      PAUSE: begin
        if (Stop) begin
          nextState_s = PAUSE;
        end else begin
          nextState_s = T0;
        end
      end
`endif
      default: nextState_s = T0;
    endcase
  end

  // State register and Run flag; Run is low only in HALT and PAUSE
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_r <= T0;
      run_r   <= 1'b0;
    end else begin
      state_r <= nextState_s;
      run_r   <= (nextState_s != HALT) && (nextState_s != PAUSE);
    end
  end

  // Moore decode of the control word from state and opcode class
  always_comb begin
    ctrl_s = '0;
    case (state_r)
      T0: begin
        ctrl_s.pcOut = 1'b1; ctrl_s.marIn = 1'b1;
        ctrl_s.aluCode = ALU_INC; ctrl_s.zIn = 1'b1;
      end
      T1: begin
        ctrl_s.zLoOut = 1'b1; ctrl_s.pcIn = 1'b1;
        ctrl_s.read = 1'b1; ctrl_s.mdrIn = 1'b1;
      end
      T2: begin
        ctrl_s.mdrOut = 1'b1; ctrl_s.irIn = 1'b1;
      end
      T3: begin
        case (opClass_s)
          CLS_RTYPE, CLS_IMM: begin
            ctrl_s.grb = 1'b1; ctrl_s.rOut = 1'b1; ctrl_s.yIn = 1'b1;
          end
          CLS_LDI, CLS_LD, CLS_ST: begin
            ctrl_s.grb = 1'b1; ctrl_s.baOut = 1'b1; ctrl_s.yIn = 1'b1;
          end
          CLS_MULDIV: begin
            ctrl_s.gra = 1'b1; ctrl_s.rOut = 1'b1; ctrl_s.yIn = 1'b1;
          end
          CLS_UNARY: begin
            ctrl_s.grb = 1'b1; ctrl_s.rOut = 1'b1;
            ctrl_s.aluCode = opcode_s; ctrl_s.zIn = 1'b1;
          end
          CLS_BR: begin
            ctrl_s.gra = 1'b1; ctrl_s.rOut = 1'b1; ctrl_s.conIn = 1'b1;
          end
          CLS_JAL: begin
            ctrl_s.pcOut = 1'b1; ctrl_s.grb = 1'b1; ctrl_s.rIn = 1'b1;
          end
          CLS_JR: begin
            ctrl_s.gra = 1'b1; ctrl_s.rOut = 1'b1; ctrl_s.pcIn = 1'b1;
          end
          CLS_IN: begin
            ctrl_s.iPortOut = 1'b1; ctrl_s.gra = 1'b1; ctrl_s.rIn = 1'b1;
          end
          CLS_OUT: begin
            ctrl_s.gra = 1'b1; ctrl_s.rOut = 1'b1; ctrl_s.oPortIn = 1'b1;
          end
          CLS_MFHI: begin
            ctrl_s.hiOut = 1'b1; ctrl_s.gra = 1'b1; ctrl_s.rIn = 1'b1;
          end
          CLS_MFLO: begin
            ctrl_s.loOut = 1'b1; ctrl_s.gra = 1'b1; ctrl_s.rIn = 1'b1;
          end
          default: ctrl_s = '0;
        endcase
      end
      T4: begin
        case (opClass_s)
          CLS_RTYPE: begin
            ctrl_s.grc = 1'b1; ctrl_s.rOut = 1'b1;
            ctrl_s.aluCode = opcode_s; ctrl_s.zIn = 1'b1;
          end
          CLS_IMM: begin
            ctrl_s.cOut = 1'b1; ctrl_s.aluCode = immAluCode(opcode_s); ctrl_s.zIn = 1'b1;
          end
          CLS_LDI, CLS_LD, CLS_ST: begin
            ctrl_s.cOut = 1'b1; ctrl_s.aluCode = ALU_ADD; ctrl_s.zIn = 1'b1;
          end
          CLS_MULDIV: begin
            ctrl_s.grb = 1'b1; ctrl_s.rOut = 1'b1;
            ctrl_s.aluCode = opcode_s; ctrl_s.zIn = 1'b1;
          end
          CLS_UNARY: begin
            ctrl_s.zLoOut = 1'b1; ctrl_s.gra = 1'b1; ctrl_s.rIn = 1'b1;
          end
          CLS_BR: begin
            ctrl_s.pcOut = 1'b1; ctrl_s.yIn = 1'b1;
          end
          CLS_JAL: begin
            ctrl_s.gra = 1'b1; ctrl_s.rOut = 1'b1; ctrl_s.pcIn = 1'b1;
          end
          default: ctrl_s = '0;
        endcase
      end
      T5: begin
        case (opClass_s)
          CLS_RTYPE, CLS_IMM, CLS_LDI: begin
            ctrl_s.zLoOut = 1'b1; ctrl_s.gra = 1'b1; ctrl_s.rIn = 1'b1;
          end
          CLS_LD, CLS_ST: begin
            ctrl_s.zLoOut = 1'b1; ctrl_s.marIn = 1'b1;
          end
          CLS_MULDIV: begin
            ctrl_s.zLoOut = 1'b1; ctrl_s.loIn = 1'b1;
          end
          CLS_BR: begin
            ctrl_s.cOut = 1'b1; ctrl_s.aluCode = ALU_ADD; ctrl_s.zIn = 1'b1;
          end
          default: ctrl_s = '0;
        endcase
      end
      T6: begin
        case (opClass_s)
          CLS_LD: begin
            ctrl_s.read = 1'b1; ctrl_s.mdrIn = 1'b1;
          end
          CLS_ST: begin
            ctrl_s.gra = 1'b1; ctrl_s.rOut = 1'b1; ctrl_s.mdrIn = 1'b1;
          end
          CLS_MULDIV: begin
            ctrl_s.zHiOut = 1'b1; ctrl_s.hiIn = 1'b1;
          end
          CLS_BR: begin
            ctrl_s.zLoOut = 1'b1; ctrl_s.pcIn = ConOut;
          end
          default: ctrl_s = '0;
        endcase
      end
      T7: begin
        case (opClass_s)
          CLS_LD: begin
            ctrl_s.mdrOut = 1'b1; ctrl_s.gra = 1'b1; ctrl_s.rIn = 1'b1;
          end
          CLS_ST: ctrl_s.write = 1'b1;
          default: ctrl_s = '0;
        endcase
      end
      default: ctrl_s = '0;
    endcase
  end

  // Hold every control low while the sequencer is in reset
  always_comb begin
    if (!clear) begin
      ctrlOut_s = '0;
    end else begin
      ctrlOut_s = ctrl_s;
    end
  end

  assign Gra      = ctrlOut_s.gra;
  assign Grb      = ctrlOut_s.grb;
  assign Grc      = ctrlOut_s.grc;
  assign RIn      = ctrlOut_s.rIn;
  assign ROut     = ctrlOut_s.rOut;
  assign BAOut    = ctrlOut_s.baOut;
  assign HiIn     = ctrlOut_s.hiIn;
  assign LoIn     = ctrlOut_s.loIn;
  assign ZIn      = ctrlOut_s.zIn;
  assign PCIn     = ctrlOut_s.pcIn;
  assign MDRIn    = ctrlOut_s.mdrIn;
  assign MARIn    = ctrlOut_s.marIn;
  assign YIn      = ctrlOut_s.yIn;
  assign OPortIn  = ctrlOut_s.oPortIn;
  assign IRIn     = ctrlOut_s.irIn;
  assign HiOut    = ctrlOut_s.hiOut;
  assign LoOut    = ctrlOut_s.loOut;
  assign ZHiOut   = ctrlOut_s.zHiOut;
  assign ZLoOut   = ctrlOut_s.zLoOut;
  assign PCOut    = ctrlOut_s.pcOut;
  assign MDROut   = ctrlOut_s.mdrOut;
  assign IPortOut = ctrlOut_s.iPortOut;
  assign COut     = ctrlOut_s.cOut;
  assign Read     = ctrlOut_s.read;
  assign Write    = ctrlOut_s.write;
  assign ConIn    = ctrlOut_s.conIn;
  assign ALUCode  = ctrlOut_s.aluCode;
  assign Run      = run_r;

endmodule

// File: doc/datapath_sequencer.md
# datapath_sequencer

Hardwired control sequencer sitting directly upstream of the datapath. It steps each instruction through fetch (T0–T2) and execute (T3–T7) and drives every register-enable, bus-select, select/encode, memory and ALU-code line consumed by the datapath. It decodes the IR opcode fed back from the datapath, uses the CON_FF result for conditional branches, and stops on `halt`.

## Interface
Parameters:
- none.

Ports:
- `clock`  in  1  sole clock, rising-edge.
- `clear`  in  1  asynchronous, active-low reset.
- `IR`  in  32  instruction register value; opcode is `IR[31:27]`.
- `ConOut`  in  1  branch-condition result from CON_FF.
- `Stop`  in  1  pause request; present only with `SEQ_STOP_EN`.
- `Gra`, `Grb`, `Grc`, `RIn`, `ROut`, `BAOut`  out  1 each  select/encode controls.
- `HiIn`, `LoIn`, `ZIn`, `PCIn`, `MDRIn`, `MARIn`, `YIn`, `OPortIn`, `IRIn`  out  1 each  register enables.
- `HiOut`, `LoOut`, `ZHiOut`, `ZLoOut`, `PCOut`, `MDROut`, `IPortOut`, `COut`  out  1 each  bus drive selects.
- `Read`, `Write`  out  1 each  memory strobes.
- `ConIn`  out  1  CON_FF load.
- `ALUCode`  out  5  ALU operation.
- `Run`  out  1  high while executing.

## Operation
- Moore outputs: decoded from the current state plus `IR[31:27]`. At most one bus-drive select is active per state.
- ALU codes:
  - R-type and unary ops send the opcode itself as `ALUCode`.
  - `addi`, `andi`, `ori` send the add, and, or codes respectively.
  - Address and offset adds use `ALU_ADD`=5'b00011.
  - PC increment uses `ALU_INC`=5'b11100.
- Fetch sequence:
  - T0: PCOut, MARIn, `ALU_INC`, ZIn.
  - T1: ZLoOut, PCIn, Read, MDRIn.
  - T2: MDROut, IRIn.
- Opcodes:
  - ld 00000, ldi 00001, st 00010.
  - add 00011, sub 00100, and 00101, or 00110, ror 00111, rol 01000, shr 01001, shra 01010, shl 01011.
  - addi 01100, andi 01101, ori 01110.
  - div 01111, mul 10000, neg 10001, not 10010.
  - br 10011, jal 10100, jr 10101.
  - in 10110, out 10111, mflo 11000, mfhi 11001.
  - nop 11010, halt 11011.
- Execute sequences. "→T0" means the next state is T0.
  - R-type: T3 Grb ROut YIn; T4 Grc ROut op ZIn; T5 ZLoOut Gra RIn →T0.
  - Immediate: T3 Grb ROut YIn; T4 COut op ZIn; T5 ZLoOut Gra RIn →T0.
  - ldi: T3 Grb BAOut YIn; T4 COut `ALU_ADD` ZIn; T5 ZLoOut Gra RIn →T0.
  - ld: T3–T4 as ldi; T5 ZLoOut MARIn; T6 Read MDRIn; T7 MDROut Gra RIn →T0.
  - st: T3–T5 as ld; T6 Gra ROut MDRIn (Read low); T7 Write →T0.
  - mul/div: T3 Gra ROut YIn; T4 Grb ROut op ZIn; T5 ZLoOut LoIn; T6 ZHiOut HiIn →T0.
  - neg/not: T3 Grb ROut op ZIn; T4 ZLoOut Gra RIn →T0.
  - br: T3 Gra ROut ConIn; T4 PCOut YIn; T5 COut `ALU_ADD` ZIn; T6 ZLoOut, with PCIn only if `ConOut`=1 →T0.
  - jal: T3 PCOut Grb RIn (the assembler places R15 in the rb field); T4 Gra ROut PCIn →T0.
  - jr: T3 Gra ROut PCIn →T0.
  - in: T3 IPortOut Gra RIn →T0.
  - out: T3 Gra ROut OPortIn →T0.
  - mfhi: T3 HiOut Gra RIn →T0.
  - mflo: T3 LoOut Gra RIn →T0.
- `nop` and undefined opcodes: T2 →T0.
- `halt`: T2 →HALT. HALT drives all outputs 0 and `Run`=0, and is left only by reset.

## Timing
- Reset (`clear`=0, asynchronous):
  - State=T0, every control output 0, `Run`=0.
  - The first rising edge after `clear` rises still performs T0, so T0 outputs are active from reset release. `Run` is 1 from that first edge.
- One state per clock. Instruction latency is 3 fetch cycles plus the execute steps above; ld/st take 8 cycles, nop takes 3.
- `IR` changes only at the end of T2. Execute decoding relies on `IR` being stable from T3 onward.
- `ConOut` is sampled in T6 of br; it reflects the ConIn load made in T3.
- Reset mid-instruction abandons the instruction, with no partial write beyond edges already taken, and returns to T0.

## Configuration
- `SEQ_STOP_EN` defined:
  - `Stop` is sampled on the edge leaving the last execute step.
  - If `Stop`=1, enter PAUSE instead of T0: all controls 0, `Run`=0.
  - Leave PAUSE to T0 on the first edge with `Stop`=0.
  - `Stop` is ignored in HALT.
- `SEQ_STOP_EN` undefined: no `Stop` port and no PAUSE state.

## Structure
- Shared package `seq_pkg` holds:
  - opcode localparams;
  - `ALU_ADD` and `ALU_INC`;
  - the state enumeration (T0–T7, HALT, PAUSE).
- One sub-module, `opcode_class_decode`: combinational; maps opcode to class (RTYPE, IMM, LDI, LD, ST, MULDIV, UNARY, BR, JAL, JR, IN, OUT, MFHI, MFLO, NOP, HALT).

## Test plan
- **Reset release:** release `clear` → T0 outputs PCOut, MARIn, ZIn, `ALUCode`=11100 active; `Run`=1.
- **add (IR=0x18918000):** cycle 4 has Grc ROut ZIn with `ALUCode`=00011; cycle 5 has ZLoOut Gra RIn; cycle 6 is T0.
- **ld:** Read and MDRIn are both high in T1 and T6; Write is never asserted; MDROut Gra RIn in T7.
- **br:** with `ConOut`=0, T6 has ZLoOut but no PCIn; with `ConOut`=1, T6 has PCIn=1.
- **halt (opcode 11011):** `Run` falls after T2 and outputs stay 0 for 20 cycles; `clear` pulse → T0.
- **Stop (`SEQ_STOP_EN`):** `Stop`=1 during an R-type T5 → PAUSE with `Run`=0; drop `Stop` → T0 next cycle.
